// File: rtl/bit_serial_adder_ctrl_pkg.sv
// Shared types for the bit-serial adder controller: FSM encoding and counter sizing.
package bsa_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter must hold 0..WIDTH (it steps once past the last bit on the exit edge).
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/bit_serial_adder_ctrl_if.sv
// Start/busy/done handshake plus operand and result buses of the bit-serial adder.
interface bit_serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start_in;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             cin_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start_in, a_in, b_in, cin_in,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start_in, a_in, b_in, cin_in,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/bit_serial_adder_ctrl_fa_cell.sv
// One-bit full adder built from two half-adder stages and an OR.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic s1, c1, c2;

  assign s1 = a ^ b;
  assign c1 = a & b;
  assign s  = s1 ^ ci;
  assign c2 = s1 & ci;
  assign co = c1 | c2;
endmodule

// File: rtl/bit_serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, LSB first, one bit per clock.
// WIDTH must match the WIDTH of the connected interface instance.
module bit_serial_adder_ctrl
  import bsa_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bit_serial_adder_ctrl_if.slave bus
);
  localparam int               CNT_W = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, r_sr, sum_q;
  logic [CNT_W-1:0] cnt;
  logic             carry, cout_q;
  logic             s_bit, c_bit, last_bit;

  fa_cell u_fa (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .ci (carry),
    .s  (s_bit),
    .co (c_bit)
  );

  assign last_bit = (cnt == LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state: accept only in IDLE, leave RUN after the MSB, DONE lasts one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start_in) state_nxt = RUN;
      RUN:     if (last_bit)     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand load on accept, shift per bit, capture result on the last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      r_sr   <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start_in) begin
            a_sr  <= bus.a_in;
            b_sr  <= bus.b_in;
            carry <= bus.cin_in;
            cnt   <= '0;
            r_sr  <= '0;
          end
        end
        RUN: begin
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          r_sr  <= {s_bit, r_sr[WIDTH-1:1]};
          carry <= c_bit;
          cnt   <= cnt + 1'b1;
          if (last_bit) begin
            sum_q  <= {s_bit, r_sr[WIDTH-1:1]};
            cout_q <= c_bit;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
endmodule

// File: doc/bit_serial_adder_ctrl.md
Name: bit_serial_adder_ctrl

Overview:
Controller that adds two WIDTH-bit operands bit-serially, one bit per clock, LSB first.
It reuses a single one-bit full-adder cell, built from two half-adder stages plus an OR, and sequences it with a small FSM, a bit counter and operand/result shift registers.
It exposes a start/busy/done handshake, so a higher-level block can trade adder area for latency.

Parameters:
WIDTH, 8, operand and result width in bits; legal range 2..32.
CNT_W, $clog2(WIDTH+1), bit-counter width; derived, not overridden.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start_in  input  1  request to begin an addition; sampled only in IDLE
a_in  input  WIDTH  operand A; sampled on the accepting edge only
b_in  input  WIDTH  operand B; sampled on the accepting edge only
cin_in  input  1  carry-in; sampled on the accepting edge only
busy  output  1  high while in RUN
done  output  1  one-cycle pulse; sum/cout valid from this cycle
sum  output  WIDTH  registered result; held until the next completion
cout  output  1  registered carry-out; held with sum

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset: asserting rst_n low at any time, including mid-RUN, forces:
  - state to IDLE;
  - busy=0, done=0, sum=0, cout=0;
  - shift registers, carry register and counter to 0.
  - The operation in flight is discarded; no done pulse is produced for it.
- States: IDLE, RUN, DONE (encoding in the package).
- IDLE:
  - On an edge with start_in=1: load a_sr<=a_in, b_sr<=b_in, carry<=cin_in, cnt<=0, r_sr<=0, then go to RUN.
  - Otherwise stay in IDLE.
- RUN, each edge:
  - Cell computes s_bit and c_bit from a_sr[0], b_sr[0] and carry.
  - a_sr and b_sr shift right by one.
  - r_sr shifts right with s_bit entering at the MSB.
  - carry<=c_bit; cnt<=cnt+1.
  - When cnt==WIDTH-1 on this edge: go to DONE, and load sum<={s_bit, r_sr[WIDTH-1:1]} and cout<=c_bit on that same edge.
- DONE:
  - done=1 for exactly one cycle; unconditionally return to IDLE on the next edge.
- busy=1 only in RUN. done and busy are never high together.
- start_in is ignored in RUN and DONE: no queueing, and operand inputs are don't-care there. The earliest next accept is the edge after DONE.
- Latency: accepting edge E0. RUN is entered after E0, and the WIDTH bit-edges are E1..EWIDTH. done is high in the cycle after EWIDTH. Back-to-back throughput is one result per WIDTH+2 cycles.
- Arithmetic: {cout,sum} == a_in + b_in + cin_in (mod 2^(WIDTH+1)) for all inputs; wrap-around shows only as cout=1.
- sum and cout change only on the completion edge or reset. Their values persist through subsequent IDLE/RUN phases.
- The counter never exceeds WIDTH-1 in RUN, and is unused outside RUN.

Decomposition:
- Package bsa_pkg holds:
  - state typedef/localparams: IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - the CNT_W derivation helper.
- Sub-module fa_cell: combinational one-bit full adder.
  - Ports a, b, ci, s, co.
  - Built as two half-adder stages (s1=a^b, c1=a&b; s=s1^ci, c2=s1&ci) with co=c1|c2.
  - Instantiated once inside bit_serial_adder_ctrl.
- All sequential logic (FSM, counter, shift registers, output registers) lives in bit_serial_adder_ctrl.

Test Plan:
1. Reset then WIDTH=8: a_in=0x35, b_in=0x4A, cin_in=0, start_in pulsed one cycle. Required: busy high 8 cycles, done in the 9th cycle after the accept edge, sum=0x7F, cout=0.
2. a_in=0xFF, b_in=0x01, cin_in=0. Required: sum=0x00, cout=1 (wrap-around). Follow with a_in=0xFF, b_in=0xFF, cin_in=1. Required: sum=0xFF, cout=1.
3. Hold start_in=1 continuously with a_in=0x10, b_in=0x20. Required: exactly one done every 10 cycles, sum=0x30 each time, no accept while busy or done.
4. Change a_in/b_in/cin_in every cycle during RUN after accepting 0x01+0x02. Required: sum=0x03, cout=0; later inputs are ignored.
5. Drop rst_n low at bit-edge 4 of 0xAA+0x55. Required: immediate busy=0, sum=0, cout=0, state IDLE, and no done pulse. A fresh 0x0F+0x01 afterwards yields sum=0x10.
6. Random regression: 1000 operand/cin triples compared against {cout,sum}==a+b+cin. Checker asserts done is a single-cycle pulse and that sum is stable between dones.
